// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Holds the access FSM encoding and address-map defaults.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage access into two half-word cycles
// on a 16-bit asynchronous SRAM; ready low stalls the pipeline.
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEF,
    parameter int          SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int         WW   = SRAM_AW - 1;
    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    state_t state, state_d;

    logic [3:0]    cnt, cnt_d;
    logic [WW-1:0] widx_q, widx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic [15:0]   rd_lo;

    logic [31:0] off;
    logic        req;
    logic        last;

    logic               acc_d;
    logic               half_d;
    logic               oe_d;
    logic               we_n_d;
    logic [SRAM_AW-1:0] addr_d;
    logic [15:0]        dq_d;

    assign req   = MEM_R_EN | MEM_W_EN;
    assign off   = address - BASE_ADDR;
    assign last  = (cnt == LAST);
    assign ready = ~req | (state == DONE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    widx_d  = off[SRAM_AW:2];
                    wdata_d = write_data;
                    wr_d    = MEM_W_EN;
                end
            end
            LOW: begin
                if (last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            HIGH: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus pins are registered from next-state values so the pads never glitch.
    always_comb begin
        acc_d  = (state_d == LOW) || (state_d == HIGH);
        half_d = (state_d == HIGH) ? HALF_HI : HALF_LO;
        oe_d   = acc_d & wr_d;
        we_n_d = ~(oe_d & (cnt_d != LAST));
        addr_d = acc_d ? {widx_d, half_d} : sram_addr;
        dq_d   = sram_dq_out;
        if (oe_d) begin
            dq_d = half_d ? wdata_d[31:16] : wdata_d[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            widx_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_lo       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            sram_addr   <= addr_d;
            sram_dq_out <= dq_d;
            sram_dq_oe  <= oe_d;
            sram_we_n   <= we_n_d;
            if (state == LOW && last && !wr_q) begin
                rd_lo <= sram_dq_in;
            end
            if (state == HIGH && last && !wr_q) begin
                read_data <= {sram_dq_in, rd_lo};
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench: driver queues expected responses, a negedge
// monitor checks bus phases and DONE results against a word-level model.
module tb_sram_mem_controller;

    localparam int          AC   = 3;
    localparam int          AW   = 18;
    localparam logic [31:0] BASE = 32'd1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;

    sram_mem_controller dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: write commits on the rising edge of we_n.
    logic [15:0] sram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0;
    always @(posedge sram_we_n) if (sram_dq_oe) sram[sram_addr] = sram_dq_out;
    assign sram_dq_in = sram[sram_addr];

    typedef struct {
        logic        wr;
        logic [16:0] widx;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } txn_t;

    txn_t        q[$];
    logic [31:0] ref_mem [logic [16:0]];
    logic [31:0] model_rd;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat = 0;
    int          done_cyc = 0;

    function automatic logic [16:0] widx_of(input logic [31:0] a);
        return 17'((a - BASE) >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic phase_check(input txn_t t, input int l);
        logic h;
        int   pos;
        if (l == 1) begin
            check("idle_we_n", 32'(sram_we_n), 32'd1);
            check("idle_oe", 32'(sram_dq_oe), 32'd0);
        end else if (l <= 2 * AC + 1) begin
            h   = (l > AC + 1);
            pos = h ? l - AC - 2 : l - 2;
            check("addr", 32'(sram_addr), 32'({t.widx, h}));
            check("oe", 32'(sram_dq_oe), 32'(t.wr));
            check("we_n", 32'(sram_we_n), 32'(!(t.wr && pos != AC - 1)));
            if (t.wr)
                check("dq_out", 32'(sram_dq_out),
                      32'(h ? t.wdata[31:16] : t.wdata[15:0]));
        end else begin
            check("busy_too_long", l, 2 * AC + 1);
        end
    endtask

    always @(negedge clk) begin
        txn_t t;
        cyc++;
        if (rst) begin
            lat = 0;
        end else if (!(MEM_R_EN | MEM_W_EN)) begin
            lat = 0;
            check("idle_ready", 32'(ready), 32'd1);
        end else if (!ready) begin
            lat++;
            if (q.size() == 0) check("unexpected_busy", 32'd1, 32'd0);
            else phase_check(q[0], lat);
        end else begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                t = q.pop_front();
                check("latency", lat, 2 * AC + 1);
                check("read_data", read_data, t.exp_rd);
                check("done_we_n", 32'(sram_we_n), 32'd1);
                check("done_oe", 32'(sram_dq_oe), 32'd0);
            end
            done_cyc = cyc;
            lat = 0;
        end
    end

    task automatic push_txn(input logic w, input logic [31:0] a,
                            input logic [31:0] d);
        txn_t t;
        t.wr    = w;
        t.widx  = widx_of(a);
        t.wdata = d;
        if (w) ref_mem[t.widx] = d;
        else model_rd = ref_mem.exists(t.widx) ? ref_mem[t.widx] : 32'h0;
        t.exp_rd = model_rd;
        q.push_back(t);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            check("done_timeout", 32'd0, 32'd1);
            q.delete();
        end
    endtask

    task automatic access(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        push_txn(w, a, d);
        @(posedge clk);
        #1;
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        address    = a;
        write_data = d;
        wait_done();
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d1;
        logic        w, r;
        logic [31:0] a;
        int          sel;

        rst        = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        address    = '0;
        write_data = '0;
        model_rd   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);

        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        check("sram_lo_word1", 32'(sram[2]), 32'h0000BEEF);
        check("sram_hi_word1", 32'(sram[3]), 32'h0000DEAD);
        idle(2);

        access(1'b1, 1'b0, 32'd1028, 32'h0);
        idle(2);

        access(1'b1, 1'b1, 32'd1024, 32'h12345678);
        check("sram_lo_word0", 32'(sram[0]), 32'h00005678);
        check("sram_hi_word0", 32'(sram[1]), 32'h00001234);
        idle(2);

        // Reset during the HIGH phase of a load, request held throughout.
        push_txn(1'b0, 32'd1028, 32'h0);
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        address  = 32'd1028;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_read_data", read_data, 32'h0);
        check("abort_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        wait_done();
        idle(2);

        access(1'b1, 1'b0, 32'd1024, 32'h0);
        d1 = done_cyc;
        access(1'b1, 1'b0, 32'd1032, 32'h0);
        check("b2b_gap", done_cyc - d1, 2 * AC + 2);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            w   = 1'($urandom_range(0, 1));
            r   = w ? 1'($urandom_range(0, 3) == 0) : 1'b1;
            a   = BASE + 32'(4 * $urandom_range(0, 31));
            sel = $urandom_range(0, 3);
            if (sel == 0) a = a + 32'h0008_0000;
            if (sel == 1) a = a - 32'h0008_0000;
            access(r, w, a, $urandom);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
        end
        idle(3);
        check("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
